row_packer: RTL
===============

// Module: row_packer
// PURPOSE
//  Upstream front-end of the day-7 beam-splitter datapath. Accepts the puzzle
//  grid as an ASCII byte stream (valid/ready) and packs each grid row into
//  WORDS_PER_ROW x 32-bit bitmask words, one word per cycle, in the
//  word order the splitter/counter stage consumes (word index 0..4 cyclic).
//  Each bit is 1 for '^' or 'S' and 0 for '.'. Every row is zero-padded to
//  160 columns, so the downstream mod-5 word counter never loses alignment.
// PARAMETERS
//  WORD_W         32  bits per output word
//  WORDS_PER_ROW  5   words per packed row; ROW_W = WORD_W*WORDS_PER_ROW = 160
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-low reset
//  in_valid       in   1   in_char is valid
//  in_ready       out  1   the block takes in_char when in_valid & in_ready
//  in_char        in   8   ASCII byte
//  in_last        in   1   with in_char: final byte of the file; acts as a trailing '\n'
//  out_valid      out  1   out_word is valid
//  out_ready      in   1   downstream takes the word (drives its enable = out_valid & out_ready)
//  out_word       out  32  packed bits; column c -> word c/32, bit 31-(c%32)
//  out_idx        out  3   word index within the row, 0..WORDS_PER_ROW-1
//  out_row_last   out  1   out_idx == WORDS_PER_ROW-1
//  overflow       out  1   sticky: a row had more than ROW_W grid characters
// BEHAVIOUR
//  - Reset (reset==0 at posedge): out_valid=0, out_word=0, out_idx=0, overflow=0,
//    column=0, word_idx=0, state=FILL. in_ready is low while reset is low.
//  - Char classes: '^','S' -> grid bit 1; '.' -> grid bit 0; '\n' -> end of row;
//    any other byte ('\r', space) -> consumed and ignored, column unchanged.
//  - Single output holding register. Slot free = !out_valid | out_ready.
//    in_ready = reset & slot free & state in {FILL, AWAIT_NL}.
//    out_word/out_idx remain stable while out_valid & !out_ready.
//  - FSM:
//    FILL: a grid char sets bit 31-col of the accumulator; col++.
//      On the 32nd char: the accumulator loads into the out register on the next
//      edge (1-cycle latency), then clears; word_idx++.
//      When word WORDS_PER_ROW-1 completes -> AWAIT_NL.
//      '\n' or in_last with col==0 and word_idx==0 (blank line): ignored, no words emitted.
//      '\n' or in_last otherwise: emit the partial word (zero-padded low bits)
//      if col>0, then -> PAD.
//    PAD: no input taken. Emit one all-zero word per free-slot cycle until the
//      word with idx WORDS_PER_ROW-1 has been emitted; then -> FILL with
//      col=0, word_idx=0.
//    AWAIT_NL: '\n'/in_last -> FILL. A grid char sets overflow, is dropped, and
//      the state holds. Ignored bytes are consumed.
//  - An 'S' is treated as a grid bit of 1. The downstream stage uses the first
//    row as its initial beam.
//  - A reset low mid-row or mid-PAD discards the partial row. No word is emitted.
// CONFIGURATION
//  ROW_PACKER_STATS_EN defined: adds outputs rows_done[15:0] (increments when the
//    idx-4 word is accepted) and split_chars[15:0] (increments per accepted '^').
//    Both are wrapping counters and reset to 0.
//  Not defined: these ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Shared package day7_pkg: WORD_W, WORDS_PER_ROW, ROW_W, ASCII constants
//    (CH_DOT 8'h2E, CH_SPLIT 8'h5E, CH_START 8'h53, CH_NL 8'h0A),
//    and the FSM state enum {FILL, PAD, AWAIT_NL}.
//  One sub-module: char_classify (combinational byte -> {is_grid, bit, is_nl}).
//  Everything else stays in row_packer.
// TESTING
//  1. Row "S" + 159 '.' + '\n', out_ready=1 -> 5 words: 0x8000_0000, then 4x 0.
//     out_idx 0..4; out_row_last only on the last word.
//  2. Row "..^.\n" -> word0=0x2000_0000, then 4 zero pad words.
//     in_ready is low during the 4 PAD cycles.
//  3. A 160-char row of '^' + '\n' -> 5x 0xFFFF_FFFF, no pad words, overflow=0.
//     Then 161 chars -> the 161st is dropped, overflow=1 and sticky.
//  4. out_ready held low 3 cycles on word1 -> out_word/out_idx stable and
//     in_ready=0. The word is accepted once on release. Nothing is lost or duplicated.
//  5. "\n\n.^\r\n" -> the blank lines emit nothing. '\r' is ignored.
//     word0=0x4000_0000 plus 4 pad words.
//  6. Last row ends with in_last on '^' at col 0 (no '\n') -> word0=0x8000_0000
//     plus 4 pads. Reset pulsed mid-row -> no partial word, next row starts at idx 0.

Source files
------------

// File: rtl/day7_pkg.sv
// Shared definitions for the day-7 row packer: row geometry, ASCII codes and FSM states.
package day7_pkg;

  localparam int WORD_W        = 32;
  localparam int ROW_W         = 160;
  localparam int WORDS_PER_ROW = ROW_W / WORD_W;
  localparam int COL_W         = $clog2(WORD_W);
  localparam int IDX_W         = 3;

  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_SPLIT = 8'h5E;
  localparam logic [7:0] CH_START = 8'h53;
  localparam logic [7:0] CH_NL    = 8'h0A;

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    PAD      = 2'd1,
    AWAIT_NL = 2'd2
  } state_e;

endpackage

// File: rtl/row_packer_char_classify.sv
// Byte classifier: maps an ASCII byte to grid/bit/newline flags; other bytes are ignorable.
module char_classify
  import day7_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_grid,
  output logic       grid_bit,
  output logic       is_nl
);

  always_comb begin
    is_grid  = 1'b0;
    grid_bit = 1'b0;
    is_nl    = 1'b0;
    case (ch)
      CH_SPLIT, CH_START: begin
        is_grid  = 1'b1;
        grid_bit = 1'b1;
      end
      CH_DOT:  is_grid = 1'b1;
      CH_NL:   is_nl   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/row_packer.sv
// Packs an ASCII grid stream into WORDS_PER_ROW x 32-bit words per row, zero-padded.
// Optional ROW_PACKER_STATS_EN adds rows_done/split_chars counters.
module row_packer
  import day7_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_row_last,
  output logic              overflow
`ifdef ROW_PACKER_STATS_EN
  ,
  output logic [15:0]       rows_done,
  output logic [15:0]       split_chars
`endif
);

  // state    | meaning
  // FILL     | accepting grid chars into the accumulator
  // PAD      | emitting zero words up to the last index, no input taken
  // AWAIT_NL | row full; dropping grid chars (overflow) until end of line

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [WORD_W-1:0] acc_q, acc_d, acc_set;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              overflow_q, overflow_d;

  logic              is_grid, grid_bit, is_nl;
  logic              slot_free, take, eol, close_word, emit;
  logic [WORD_W-1:0] emit_word;

  char_classify u_classify (
    .ch       (in_char),
    .is_grid  (is_grid),
    .grid_bit (grid_bit),
    .is_nl    (is_nl)
  );

  assign slot_free = !out_valid_q | out_ready;
  assign in_ready  = reset & slot_free & ((state_q == FILL) | (state_q == AWAIT_NL));
  assign take      = in_valid & in_ready;
  assign eol       = is_nl | in_last;

  // A word closes on its last column, or on end-of-line with pending columns.
  assign close_word = take & (state_q == FILL) &
                      ((is_grid & (col_q == COL_MAX)) | (eol & (is_grid | (col_q != '0))));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    word_idx_d  = word_idx_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;
    out_word_d  = out_word_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q & !out_ready;
    emit        = 1'b0;
    emit_word   = '0;
    acc_set     = acc_q;
    if (is_grid & grid_bit) acc_set[COL_MAX - col_q] = 1'b1;

    case (state_q)
      FILL: begin
        if (close_word) begin
          emit      = 1'b1;
          emit_word = acc_set;
          acc_d     = '0;
          col_d     = '0;
          if (word_idx_q == LAST_IDX) begin
            word_idx_d = '0;
            state_d    = eol ? FILL : AWAIT_NL;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            state_d    = eol ? PAD : FILL;
          end
        end else if (take & is_grid) begin
          acc_d = acc_set;
          col_d = col_q + 1'b1;
        end else if (take & eol & (word_idx_q != '0)) begin
          state_d = PAD;
        end
      end
      PAD: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_word = '0;
          if (word_idx_q == LAST_IDX) begin
            word_idx_d = '0;
            state_d    = FILL;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      AWAIT_NL: begin
        if (take) begin
          if (is_grid) overflow_d = 1'b1;
          if (eol)     state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_word_d  = emit_word;
      out_idx_d   = word_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      col_q       <= '0;
      word_idx_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      word_idx_q  <= word_idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_idx_q   <= out_idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_word     = out_word_q;
  assign out_idx      = out_idx_q;
  assign out_row_last = (out_idx_q == LAST_IDX);
  assign overflow     = overflow_q;

`ifdef ROW_PACKER_STATS_EN
  logic [15:0] rows_done_q, rows_done_d;
  logic [15:0] split_chars_q, split_chars_d;

  always_comb begin
    rows_done_d   = rows_done_q;
    split_chars_d = split_chars_q;
    if (out_valid_q & out_ready & (out_idx_q == LAST_IDX)) rows_done_d = rows_done_q + 16'd1;
    if (take & (in_char == CH_SPLIT)) split_chars_d = split_chars_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_done_q   <= '0;
      split_chars_q <= '0;
    end else begin
      rows_done_q   <= rows_done_d;
      split_chars_q <= split_chars_d;
    end
  end

  assign rows_done   = rows_done_q;
  assign split_chars = split_chars_q;
`endif

endmodule
